// File: rtl/pdm_audio_pkg.sv
// pdm_audio_pkg: shared defaults, dither LFSR constants and sample type for the PDM playback path
package pdm_audio_pkg;
  localparam int DEF_SAMPLE_W = 16;
  localparam int DEF_CLK_DIV = 40;
  localparam int DEF_OSR = 64;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;
  typedef logic signed [DEF_SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/pdm_sample_fifo.sv
// pdm_sample_fifo: synchronous sample FIFO with full/empty derived from an occupancy count
module pdm_sample_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign dout = mem[rp];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
endmodule

// File: rtl/pdm_audio_tx.sv
// pdm_audio_tx: buffered PCM to first-order sigma-delta PDM output; PDM_DITHER_EN adds LFSR dither
module pdm_audio_tx
  import pdm_audio_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int OSR = DEF_OSR,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                pdm_out,
  output logic                aud_sd,
  output logic                underrun,
  input  logic                underrun_clr
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(OSR);
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt;
  logic [SAMPLE_W-1:0] acc, cur, fifo_dout, u, ud;
  logic [SAMPLE_W:0] sum;
  logic tick, frame_end, pop, push, full, empty, rdy_en;
  assign tick = enable && div_cnt == DW'(CLK_DIV-1);
  assign frame_end = tick && bit_cnt == BW'(OSR-1);
  assign pop = frame_end && !empty;
  assign sample_ready = rdy_en && !full;
  assign push = sample_valid && sample_ready;
  // offset binary: most negative sample maps to 0, most positive to all ones
  assign u = {~cur[SAMPLE_W-1], cur[SAMPLE_W-2:0]};
`ifdef PDM_DITHER_EN
  logic [15:0] lfsr;
  assign ud = (&u) ? u : u + SAMPLE_W'(lfsr[0]);
  always_ff @(posedge clk or negedge reset)
    if (!reset) lfsr <= LFSR_SEED;
    else if (tick) lfsr <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
`else
  assign ud = u;
`endif
  assign sum = {1'b0, acc} + {1'b0, ud};
  pdm_sample_fifo #(.W(SAMPLE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(sample_in),
    .dout(fifo_dout), .full(full), .empty(empty)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      acc <= '0;
      cur <= '0;
      pdm_out <= 1'b0;
      aud_sd <= 1'b0;
      underrun <= 1'b0;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      aud_sd <= enable;
      underrun <= (frame_end && empty) || (underrun && !underrun_clr);
      if (pop) cur <= fifo_dout;
      if (!enable) begin
        div_cnt <= '0;
        bit_cnt <= '0;
        acc <= '0;
        pdm_out <= 1'b0;
      end else begin
        div_cnt <= tick ? '0 : div_cnt + DW'(1);
        if (tick) begin
          bit_cnt <= frame_end ? '0 : bit_cnt + BW'(1);
          acc <= sum[SAMPLE_W-1:0];
          pdm_out <= sum[SAMPLE_W];
        end
      end
    end
endmodule

// File: tb/tb_pdm_audio_tx.sv
// tb_pdm_audio_tx: randomized self-checking bench against a sample-level sigma-delta reference
module tb_pdm_audio_tx;
  import pdm_audio_pkg::*;
  localparam int CLK_DIV = 4, OSR = 16, DEPTH = 4, FW = CLK_DIV * OSR;
`ifdef PDM_DITHER_EN
  localparam int HI = 65535 + OSR;
`else
  localparam int HI = 65535;
`endif
  logic clk = 0, reset = 0, enable = 0, sample_valid = 0, underrun_clr = 0;
  logic [15:0] sample_in = '0;
  logic sample_ready, pdm_out, aud_sd, underrun;
  int errors = 0, checks = 0;
  logic [15:0] src[$];
  bit feed_en = 0;
  sample_t q[$];
  sample_t m_cur = '0, m_fcur = '0;
  int m_cnt = 0, m_acc = 0, d_ones = 0, u = 0;
  logic m_pdm = 0, m_sd = 0, m_under = 0, m_ready = 0, m_rdyen = 0;
  bit m_tick = 0, m_bound = 0, m_restart = 1, tk, bd, st, ps;
  logic [15:0] lfsr = 16'hACE1;
  int fr_ones[$];
  sample_t fr_cur[$];

  pdm_audio_tx #(.SAMPLE_W(16), .CLK_DIV(CLK_DIV), .OSR(OSR), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .enable(enable), .sample_in(sample_in),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .pdm_out(pdm_out),
    .aud_sd(aud_sd), .underrun(underrun), .underrun_clr(underrun_clr)
  );

  always #5 clk = ~clk;

  // reference: tick n falls on cycle CLK_DIV*n+CLK_DIV-1 after enable; sigma-delta as integer density
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      m_cnt = 0; m_acc = 0; m_cur = '0; m_pdm = 0; m_sd = 0; m_under = 0;
      m_rdyen = 0; m_ready = 0; m_tick = 0; m_bound = 0; m_restart = 1; lfsr = 16'hACE1;
    end else begin
      ps = sample_valid && m_rdyen && q.size() < DEPTH;
      tk = enable && (m_cnt % CLK_DIV == CLK_DIV - 1);
      bd = tk && ((m_cnt / CLK_DIV) % OSR == OSR - 1);
      st = bd && q.size() == 0;
      m_fcur = m_cur;
      if (tk) begin
        u = int'(m_cur) + 32768;
`ifdef PDM_DITHER_EN
        u = u + int'(lfsr[0]);
        if (u > 65535) u = 65535;
        lfsr = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
`endif
        m_acc = m_acc + u;
        m_pdm = m_acc >= 65536;
        if (m_pdm) m_acc = m_acc - 65536;
      end
      if (bd && q.size() > 0) m_cur = q.pop_front();
      if (ps) begin
        q.push_back(sample_in);
        if (src.size() > 0) void'(src.pop_front());
      end
      m_under = st || (m_under && !underrun_clr);
      if (!enable) begin m_cnt = 0; m_acc = 0; m_pdm = 0; end else m_cnt++;
      m_sd = enable; m_rdyen = 1; m_ready = q.size() < DEPTH;
      m_tick = tk; m_bound = bd; m_restart = !enable;
    end
  end

  always @(negedge clk) if (feed_en) begin
    sample_valid = src.size() > 0;
    sample_in = src.size() > 0 ? src[0] : 16'h0;
  end

  always @(negedge clk) begin
    if (m_restart) d_ones = 0;
    else if (m_tick) begin
      d_ones += int'(pdm_out);
      if (m_bound) begin fr_ones.push_back(d_ones); fr_cur.push_back(m_fcur); d_ones = 0; end
    end
  end

  task test_reset;
    reset = 0; feed_en = 0; sample_valid = 1; sample_in = 16'($urandom);
    repeat (5) begin
      @(negedge clk); checks++;
      if ({pdm_out, aud_sd, underrun, sample_ready} !== 4'b0) begin
        errors++; $display("FAIL reset_outputs got pdm/sd/und/rdy=%b want 0000", {pdm_out, aud_sd, underrun, sample_ready});
      end
    end
    sample_valid = 0; reset = 1;
    @(negedge clk); checks++;
    if (sample_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b want 1", sample_ready); end
    feed_en = 1;
  endtask

  task test_zero_density;
    logic prev;
    fr_ones.delete(); fr_cur.delete();
    repeat (6) src.push_back(16'h0000);
    enable = 1; prev = pdm_out;
    repeat (5 * FW) begin
      @(negedge clk); checks++;
      if ({pdm_out, sample_ready, underrun, aud_sd} !== {m_pdm, m_ready, m_under, m_sd}) begin
        errors++; $display("FAIL zero_cycle t=%0t got pdm/rdy/und/sd=%b want %b", $time, {pdm_out, sample_ready, underrun, aud_sd}, {m_pdm, m_ready, m_under, m_sd});
      end
      checks++;
      if (pdm_out !== prev && !m_tick) begin errors++; $display("FAIL zero_toggle_timing t=%0t got change off-tick want change only after tick", $time); end
      prev = pdm_out;
    end
    foreach (fr_ones[i]) begin
      checks++;
      if (fr_ones[i] * 65536 - OSR * (int'(fr_cur[i]) + 32768) <= -65536 || fr_ones[i] * 65536 - OSR * (int'(fr_cur[i]) + 32768) > HI) begin
        errors++; $display("FAIL zero_frame_density sample=%h got ones=%0d", fr_cur[i], fr_ones[i]);
      end
    end
  endtask

  task test_extremes;
    bit seen_hi, seen_lo;
    fr_ones.delete(); fr_cur.delete(); seen_hi = 0; seen_lo = 0;
    src.push_back(16'h7FFF); src.push_back(16'h8000);
    repeat (5 * FW) begin
      @(negedge clk); checks++;
      if ({pdm_out, sample_ready, underrun, aud_sd} !== {m_pdm, m_ready, m_under, m_sd}) begin
        errors++; $display("FAIL extreme_cycle t=%0t got pdm/rdy/und/sd=%b want %b", $time, {pdm_out, sample_ready, underrun, aud_sd}, {m_pdm, m_ready, m_under, m_sd});
      end
    end
    foreach (fr_ones[i]) begin
      if (fr_cur[i] == 16'sh7FFF) seen_hi = 1;
      if (fr_cur[i] == -16'sh8000) seen_lo = 1;
      checks++;
      if (fr_ones[i] * 65536 - OSR * (int'(fr_cur[i]) + 32768) <= -65536 || fr_ones[i] * 65536 - OSR * (int'(fr_cur[i]) + 32768) > HI) begin
        errors++; $display("FAIL extreme_frame_density sample=%h got ones=%0d", fr_cur[i], fr_ones[i]);
      end
    end
    checks++;
    if (!(seen_hi && seen_lo)) begin errors++; $display("FAIL extreme_frames_seen got hi=%0d lo=%0d want 1 1", seen_hi, seen_lo); end
  endtask

  task test_fill_disabled;
    int got;
    enable = 0; got = -1;
    repeat (5) src.push_back(16'($urandom));
    repeat (10) begin
      @(negedge clk); checks++;
      if ({pdm_out, sample_ready, underrun, aud_sd} !== {m_pdm, m_ready, m_under, m_sd}) begin
        errors++; $display("FAIL fill_cycle t=%0t got pdm/rdy/und/sd=%b want %b", $time, {pdm_out, sample_ready, underrun, aud_sd}, {m_pdm, m_ready, m_under, m_sd});
      end
    end
    checks++;
    if (sample_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready got %b want 0", sample_ready); end
    enable = 1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk); checks++;
      if ({pdm_out, sample_ready, underrun, aud_sd} !== {m_pdm, m_ready, m_under, m_sd}) begin
        errors++; $display("FAIL fill_resume_cycle t=%0t got %b want %b", $time, {pdm_out, sample_ready, underrun, aud_sd}, {m_pdm, m_ready, m_under, m_sd});
      end
      if (sample_ready === 1'b1) begin got = i; break; end
    end
    checks++;
    if (got != FW) begin errors++; $display("FAIL fill_ready_latency got %0d want %0d cycles", got, FW); end
  endtask

  task test_underrun;
    int waited;
    fr_ones.delete(); fr_cur.delete(); waited = -1;
    underrun_clr = 1; @(negedge clk); underrun_clr = 0; @(negedge clk); checks++;
    if (underrun !== m_under) begin errors++; $display("FAIL underrun_initial_clear got %b want %b", underrun, m_under); end
    for (int i = 0; i < 8 * FW; i++) begin
      @(negedge clk); checks++;
      if ({pdm_out, sample_ready, underrun, aud_sd} !== {m_pdm, m_ready, m_under, m_sd}) begin
        errors++; $display("FAIL underrun_cycle t=%0t got %b want %b", $time, {pdm_out, sample_ready, underrun, aud_sd}, {m_pdm, m_ready, m_under, m_sd});
      end
      if (underrun === 1'b1) begin waited = i; break; end
    end
    checks++;
    if (waited < 0) begin errors++; $display("FAIL underrun_timeout got underrun=%b want 1", underrun); end
    repeat (2 * FW) @(negedge clk);
    foreach (fr_ones[i]) begin
      checks++;
      if (fr_ones[i] * 65536 - OSR * (int'(fr_cur[i]) + 32768) <= -65536 || fr_ones[i] * 65536 - OSR * (int'(fr_cur[i]) + 32768) > HI) begin
        errors++; $display("FAIL underrun_hold_density sample=%h got ones=%0d", fr_cur[i], fr_ones[i]);
      end
    end
    while (m_cnt % FW == FW - 1) @(negedge clk);
    underrun_clr = 1; @(negedge clk); underrun_clr = 0; checks++;
    if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_clear got %b want 0", underrun); end
    for (int i = 0; i < 2 * FW && m_cnt % FW != FW - 1; i++) @(negedge clk);
    underrun_clr = 1; @(negedge clk); underrun_clr = 0; checks++;
    if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_set_wins got %b want 1", underrun); end
  endtask

  task test_back_to_back;
    fr_ones.delete(); fr_cur.delete();
    repeat (10) src.push_back(16'($urandom));
    repeat (11 * FW) begin
      @(negedge clk); checks++;
      if ({pdm_out, sample_ready, underrun, aud_sd} !== {m_pdm, m_ready, m_under, m_sd}) begin
        errors++; $display("FAIL b2b_cycle t=%0t got %b want %b", $time, {pdm_out, sample_ready, underrun, aud_sd}, {m_pdm, m_ready, m_under, m_sd});
      end
      if ($urandom_range(0, 15) == 0) underrun_clr = 1; else underrun_clr = 0;
    end
    underrun_clr = 0;
    foreach (fr_ones[i]) begin
      checks++;
      if (fr_ones[i] * 65536 - OSR * (int'(fr_cur[i]) + 32768) <= -65536 || fr_ones[i] * 65536 - OSR * (int'(fr_cur[i]) + 32768) > HI) begin
        errors++; $display("FAIL b2b_frame_density sample=%h got ones=%0d", fr_cur[i], fr_ones[i]);
      end
    end
  endtask

  task test_reset_mid_frame;
    repeat (3) src.push_back(16'($urandom));
    for (int i = 0; i < 50 && src.size() > 0; i++) @(negedge clk);
    for (int i = 0; i < 2 * FW && m_cnt % FW != 7 * CLK_DIV + 1; i++) @(negedge clk);
    reset = 0; #1; checks++;
    if ({pdm_out, aud_sd, underrun, sample_ready} !== 4'b0) begin
      errors++; $display("FAIL midframe_reset got pdm/sd/und/rdy=%b want 0000", {pdm_out, aud_sd, underrun, sample_ready});
    end
    @(negedge clk); reset = 1;
    repeat (FW + 4) begin
      @(negedge clk); checks++;
      if ({pdm_out, sample_ready, underrun, aud_sd} !== {m_pdm, m_ready, m_under, m_sd}) begin
        errors++; $display("FAIL midframe_cycle t=%0t got %b want %b", $time, {pdm_out, sample_ready, underrun, aud_sd}, {m_pdm, m_ready, m_under, m_sd});
      end
    end
    checks++;
    if (underrun !== 1'b1) begin errors++; $display("FAIL midframe_fifo_empty got underrun=%b want 1", underrun); end
  endtask

  initial begin
    test_reset;
    test_zero_density;
    test_extremes;
    test_fill_disabled;
    test_underrun;
    test_back_to_back;
    test_reset_mid_frame;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
